// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request/response bundle between an instruction requester and instr_encoder
interface instr_encoder_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_kind;
    logic [3:0]    req_op;
    logic [4:0]    req_rd;
    logic [4:0]    req_rs1;
    logic [4:0]    req_rs2;
    logic [31:0]   req_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic          err_illegal;
    logic [CW-1:0] count;

    modport master (
        output req_valid, req_kind, req_op, req_rd, req_rs1, req_rs2, req_imm, out_ready,
        input  req_ready, out_valid, out_instr, err_illegal, count
    );

    modport slave (
        input  req_valid, req_kind, req_op, req_rd, req_rs1, req_rs2, req_imm, out_ready,
        output req_ready, out_valid, out_instr, err_illegal, count
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with output word FIFO
// Define INSTR_ENC_LI_EN to enable the LI pseudo-op (LUI+ADDI expansion).
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_encoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    localparam logic [3:0] K_OP     = 4'd0;
    localparam logic [3:0] K_OP_IMM = 4'd1;
    localparam logic [3:0] K_LOAD   = 4'd2;
    localparam logic [3:0] K_STORE  = 4'd3;
    localparam logic [3:0] K_BRANCH = 4'd4;
    localparam logic [3:0] K_JAL    = 4'd5;
    localparam logic [3:0] K_JALR   = 4'd6;
    localparam logic [3:0] K_LUI    = 4'd7;
    localparam logic [3:0] K_AUIPC  = 4'd8;
`ifdef INSTR_ENC_LI_EN
    localparam logic [3:0] K_LI     = 4'd9;
`endif

    // ALU operation codes shared with the decode-stage control unit
    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_SLL  = 4'd2;
    localparam logic [3:0] ALU_OP_SLT  = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU = 4'd4;
    localparam logic [3:0] ALU_OP_XOR  = 4'd5;
    localparam logic [3:0] ALU_OP_SRL  = 4'd6;
    localparam logic [3:0] ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] ALU_OP_OR   = 4'd8;
    localparam logic [3:0] ALU_OP_AND  = 4'd9;
    localparam logic [3:0] ALU_OP_ID_A = 4'd10;
    localparam logic [3:0] ALU_OP_ID_B = 4'd11;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] i12, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {i12, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] i12, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {i12[11:5], rs2, rs1, f3, i12[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] i13, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {i13[12], i13[10:5], rs2, rs1, f3, i13[4:1], i13[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] i21, input logic [4:0] rd);
        return {i21[20], i21[10:1], i21[11], i21[19:12], rd, OPC_JAL};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] hi, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {hi, rd, opc};
    endfunction

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          err_q;

    logic [31:0] imm;
    logic [2:0]  alu_f3;
    logic        alu_alt;
    logic        alu_bad;
    logic        alu_shift;
    logic        fits_i;
    logic        fits_b;
    logic        fits_j;
    logic        shamt_ok;
    logic        illegal;
    logic [1:0]  need;
    logic [31:0] w0;
`ifdef INSTR_ENC_LI_EN
    logic [31:0] w1;
    logic [19:0] li_hi;
`endif
    logic [CW-1:0] free;
    logic          accept;
    logic          pop;

    always_comb begin
        alu_f3    = 3'b000;
        alu_alt   = 1'b0;
        alu_bad   = 1'b0;
        alu_shift = 1'b0;
        case (bus.req_op)
            ALU_OP_ADD:  alu_f3 = 3'b000;
            ALU_OP_SUB:  begin alu_f3 = 3'b000; alu_alt = 1'b1; end
            ALU_OP_SLL:  begin alu_f3 = 3'b001; alu_shift = 1'b1; end
            ALU_OP_SLT:  alu_f3 = 3'b010;
            ALU_OP_SLTU: alu_f3 = 3'b011;
            ALU_OP_XOR:  alu_f3 = 3'b100;
            ALU_OP_SRL:  begin alu_f3 = 3'b101; alu_shift = 1'b1; end
            ALU_OP_SRA:  begin alu_f3 = 3'b101; alu_shift = 1'b1; alu_alt = 1'b1; end
            ALU_OP_OR:   alu_f3 = 3'b110;
            ALU_OP_AND:  alu_f3 = 3'b111;
            ALU_OP_ID_A, ALU_OP_ID_B: alu_bad = 1'b1;
            default:     alu_bad = 1'b1;
        endcase
    end

    // Range checks reduce to "all bits above the field equal the field's sign bit"
    assign imm      = bus.req_imm;
    assign fits_i   = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits_b   = ~imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
    assign fits_j   = ~imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));
    assign shamt_ok = ~(|imm[31:5]);
`ifdef INSTR_ENC_LI_EN
    // (imm + 0x800) >> 12: the low half carries into bit 12 exactly when imm[11] is set
    assign li_hi    = imm[31:12] + {19'd0, imm[11]};
`endif

    always_comb begin
        illegal = 1'b0;
        need    = 2'd1;
        w0      = NOP;
`ifdef INSTR_ENC_LI_EN
        w1      = NOP;
`endif
        case (bus.req_kind)
            K_OP: begin
                illegal = alu_bad;
                w0 = enc_r({1'b0, alu_alt, 5'd0}, bus.req_rs2, bus.req_rs1, alu_f3,
                           bus.req_rd, OPC_OP);
            end
            K_OP_IMM: begin
                if (alu_shift) begin
                    illegal = ~shamt_ok;
                    w0 = enc_r({1'b0, alu_alt, 5'd0}, imm[4:0], bus.req_rs1, alu_f3,
                               bus.req_rd, OPC_OP_IMM);
                end else begin
                    illegal = alu_bad | (bus.req_op == ALU_OP_SUB) | ~fits_i;
                    w0 = enc_i(imm[11:0], bus.req_rs1, alu_f3, bus.req_rd, OPC_OP_IMM);
                end
            end
            K_LOAD: begin
                illegal = (bus.req_op[2:0] == 3'b011) | (bus.req_op[2:0] == 3'b110) |
                          (bus.req_op[2:0] == 3'b111) | ~fits_i;
                w0 = enc_i(imm[11:0], bus.req_rs1, bus.req_op[2:0], bus.req_rd, OPC_LOAD);
            end
            K_STORE: begin
                illegal = (bus.req_op[2:0] > 3'b010) | ~fits_i;
                w0 = enc_s(imm[11:0], bus.req_rs2, bus.req_rs1, bus.req_op[2:0]);
            end
            K_BRANCH: begin
                illegal = (bus.req_op[2:1] == 2'b01) | ~fits_b;
                w0 = enc_b(imm[12:0], bus.req_rs2, bus.req_rs1, bus.req_op[2:0]);
            end
            K_JAL: begin
                illegal = ~fits_j;
                w0 = enc_j(imm[20:0], bus.req_rd);
            end
            K_JALR: begin
                illegal = ~fits_i;
                w0 = enc_i(imm[11:0], bus.req_rs1, 3'b000, bus.req_rd, OPC_JALR);
            end
            K_LUI:   w0 = enc_u(imm[31:12], bus.req_rd, OPC_LUI);
            K_AUIPC: w0 = enc_u(imm[31:12], bus.req_rd, OPC_AUIPC);
`ifdef INSTR_ENC_LI_EN
            K_LI: begin
                if (fits_i) begin
                    w0 = enc_i(imm[11:0], 5'd0, 3'b000, bus.req_rd, OPC_OP_IMM);
                end else begin
                    w0   = enc_u(li_hi, bus.req_rd, OPC_LUI);
                    w1   = enc_i(imm[11:0], bus.req_rd, 3'b000, bus.req_rd, OPC_OP_IMM);
                    need = (imm[11:0] != 12'd0) ? 2'd2 : 2'd1;
                end
            end
`endif
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            need = 2'd0;
        end
    end

    // Space is judged on the registered count only; a same-cycle pop never helps
    assign free          = DEPTH_C - cnt;
    assign bus.req_ready = rst_n & (free >= CW'(need));
    assign accept        = bus.req_valid & bus.req_ready;
    assign bus.out_valid = (cnt != '0);
    assign pop           = bus.out_valid & bus.out_ready;
    assign bus.out_instr = bus.out_valid ? mem[rd_ptr] : NOP;
    assign bus.count     = cnt;
    assign bus.err_illegal = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= accept & illegal;
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(need);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + (accept ? CW'(need) : '0) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept && need != 2'd0) begin
            mem[wr_ptr] <= w0;
        end
`ifdef INSTR_ENC_LI_EN
        if (accept && need == 2'd2) begin
            mem[wr_ptr + 1'b1] <= w1;
        end
`endif
    end
endmodule
